// File: rtl/midi_voice_allocator_pkg.sv
// Shared MIDI constants (status nibbles, controller numbers) and slot command encoding.
// Other MIDI blocks import this package for the same constants.
package midi_voice_allocator_pkg;

  localparam logic [3:0] CMD_NOTE_OFF = 4'h8;
  localparam logic [3:0] CMD_NOTE_ON  = 4'h9;
  localparam logic [3:0] CMD_CC       = 4'hB;

  localparam logic [6:0] CC_SUSTAIN        = 7'd64;
  localparam logic [6:0] CC_ALL_SOUND_OFF  = 7'd120;
  localparam logic [6:0] CC_ALL_NOTES_OFF  = 7'd123;

  typedef enum logic [2:0] {
    OpNone,
    OpStart,
    OpRetrig,
    OpSustain,
    OpRelease
  } slot_op_e;

endpackage

// File: rtl/voice_slot.sv
// One voice slot: note, velocity, gate, sustained flag and retrigger countdown.
// The top level decides what happens to the slot; this block only holds and sequences state.
module voice_slot
  import midi_voice_allocator_pkg::*;
#(
  parameter int unsigned RETRIG_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  slot_op_e   op,
  input  logic [6:0] op_note,
  input  logic [6:0] op_velocity,
  output logic       gate,
  output logic       sustained,
  output logic       retrig,
  output logic [6:0] note,
  output logic [6:0] velocity
);

  logic [7:0] count_q, count_d;
  logic       gate_q, gate_d;
  logic       sus_q, sus_d;
  logic [6:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      gate_q  <= 1'b0;
      sus_q   <= 1'b0;
      note_q  <= '0;
      vel_q   <= '0;
    end else begin
      count_q <= count_d;
      gate_q  <= gate_d;
      sus_q   <= sus_d;
      note_q  <= note_d;
      vel_q   <= vel_d;
    end
  end

  always_comb begin
    note_d  = note_q;
    vel_d   = vel_q;
    gate_d  = gate_q;
    sus_d   = sus_q;
    count_d = count_q;
    // Countdown reopens the gate on the edge that takes the counter from 1 to 0.
    if (count_q != 8'd0) begin
      count_d = count_q - 8'd1;
      if (count_q == 8'd1) gate_d = 1'b1;
    end
    unique case (op)
      OpStart: begin
        note_d  = op_note;
        vel_d   = op_velocity;
        gate_d  = 1'b1;
        sus_d   = 1'b0;
        count_d = '0;
      end
      OpRetrig: begin
        note_d  = op_note;
        vel_d   = op_velocity;
        gate_d  = 1'b0;
        sus_d   = 1'b0;
        count_d = 8'(RETRIG_CYCLES);
      end
      OpSustain: sus_d = 1'b1;
      OpRelease: begin
        gate_d  = 1'b0;
        sus_d   = 1'b0;
        count_d = '0;
      end
      default: ;
    endcase
  end

  assign gate      = gate_q;
  assign sustained = sus_q;
  assign retrig    = (count_q != 8'd0);
  assign note      = note_q;
  assign velocity  = vel_q;

endmodule

// File: rtl/midi_voice_allocator.sv
// MIDI note/CC decoder with LRU voice allocation and stealing across NUM_VOICES slots.
// Slot state lives in voice_slot; slot choice, ages and sustain pedal live here.
module midi_voice_allocator
  import midi_voice_allocator_pkg::*;
#(
  parameter int unsigned NUM_VOICES    = 8,
  parameter int unsigned MIDI_CHANNEL  = 16,
  parameter int unsigned RETRIG_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    midi_event_valid,
  input  logic [7:0]              midi_command,
  input  logic [6:0]              midi_parameter_1,
  input  logic [6:0]              midi_parameter_2,
  output logic                    midi_event_ack,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_velocity
);

  localparam int unsigned IdxW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  typedef logic [IdxW-1:0] idx_t;

  idx_t                  age_q [NUM_VOICES];
  idx_t                  age_d [NUM_VOICES];
  logic                  ack_q;
  logic                  sustain_q, sustain_d;
  logic [NUM_VOICES-1:0] gate, sustained, retrig, free;
  slot_op_e              slot_op [NUM_VOICES];

  logic       accept, chan_ok, is_on, is_off, is_cc;
  logic [3:0] cmd_type;
  logic       hit, free_any;
  idx_t       hit_idx, free_idx, free_age, steal_idx, target;

  assign cmd_type = midi_command[7:4];
  assign chan_ok  = (MIDI_CHANNEL >= 16) || (midi_command[3:0] == 4'(MIDI_CHANNEL));
  assign accept   = midi_event_valid && !ack_q;
  assign is_on    = accept && chan_ok && (cmd_type == CMD_NOTE_ON) && (midi_parameter_2 != 7'd0);
  assign is_off   = accept && chan_ok && ((cmd_type == CMD_NOTE_OFF) ||
                    ((cmd_type == CMD_NOTE_ON) && (midi_parameter_2 == 7'd0)));
  assign is_cc    = accept && chan_ok && (cmd_type == CMD_CC);
  assign free     = ~gate & ~sustained & ~retrig;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q     <= 1'b0;
      sustain_q <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= idx_t'(i);
    end else begin
      ack_q     <= accept;
      sustain_q <= sustain_d;
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= age_d[i];
    end
  end

  // Target selection: held note first, then the oldest free slot, else the oldest slot.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
      if ((gate[i] || retrig[i]) && (voice_note[7*i +: 7] == midi_parameter_1)) begin
        hit     = 1'b1;
        hit_idx = idx_t'(i);
      end
    end
    free_any = 1'b0;
    free_idx = '0;
    free_age = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (free[i] && (!free_any || (age_q[i] > free_age))) begin
        free_any = 1'b1;
        free_idx = idx_t'(i);
        free_age = age_q[i];
      end
    end
    steal_idx = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (age_q[i] == idx_t'(NUM_VOICES - 1)) steal_idx = idx_t'(i);
    end
    target = hit ? hit_idx : (free_any ? free_idx : steal_idx);
  end

  always_comb begin
    sustain_d = sustain_q;
    for (int i = 0; i < NUM_VOICES; i++) begin
      slot_op[i] = OpNone;
      age_d[i]   = age_q[i];
    end
    if (is_on) begin
      slot_op[target] = (hit || !free_any) ? OpRetrig : OpStart;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (idx_t'(i) == target)        age_d[i] = '0;
        else if (age_q[i] < age_q[target]) age_d[i] = age_q[i] + idx_t'(1);
      end
    end
    if (is_off) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if ((gate[i] || retrig[i]) && (voice_note[7*i +: 7] == midi_parameter_1)) begin
          slot_op[i] = sustain_q ? OpSustain : OpRelease;
        end
      end
    end
    if (is_cc) begin
      if (midi_parameter_1 == CC_SUSTAIN) begin
        sustain_d = midi_parameter_2[6];
        if (!midi_parameter_2[6]) begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (sustained[i]) slot_op[i] = OpRelease;
          end
        end
      end else if ((midi_parameter_1 == CC_ALL_SOUND_OFF) ||
                   (midi_parameter_1 == CC_ALL_NOTES_OFF)) begin
        for (int i = 0; i < NUM_VOICES; i++) slot_op[i] = OpRelease;
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
    voice_slot #(
      .RETRIG_CYCLES (RETRIG_CYCLES)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .op          (slot_op[g]),
      .op_note     (midi_parameter_1),
      .op_velocity (midi_parameter_2),
      .gate        (gate[g]),
      .sustained   (sustained[g]),
      .retrig      (retrig[g]),
      .note        (voice_note[7*g +: 7]),
      .velocity    (voice_velocity[7*g +: 7])
    );
  end

  assign midi_event_ack = ack_q;
  assign voice_gate     = gate;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Bench for midi_voice_allocator: directed scenarios plus random traffic against an LRU-list model.
// A second instance filters on channel 3.
module tb_midi_voice_allocator;
  localparam int N = 4;
  localparam int R = 4;

  logic clk = 1'b0, rst = 1'b0, valid = 1'b0, valid3 = 1'b0;
  logic [7:0] cmd = '0;
  logic [6:0] p1 = '0, p2 = '0;
  logic ack, ack3;
  logic [N-1:0] gate, gate3;
  logic [7*N-1:0] note, vel, note3, vel3;
  int tests = 0, fails = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  midi_voice_allocator #(.NUM_VOICES(N), .MIDI_CHANNEL(16), .RETRIG_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .midi_event_valid(valid), .midi_command(cmd),
    .midi_parameter_1(p1), .midi_parameter_2(p2), .midi_event_ack(ack),
    .voice_gate(gate), .voice_note(note), .voice_velocity(vel));

  midi_voice_allocator #(.NUM_VOICES(N), .MIDI_CHANNEL(3), .RETRIG_CYCLES(R)) dut3 (
    .clk(clk), .rst(rst), .midi_event_valid(valid3), .midi_command(cmd),
    .midi_parameter_1(p1), .midi_parameter_2(p2), .midi_event_ack(ack3),
    .voice_gate(gate3), .voice_note(note3), .voice_velocity(vel3));

  // Model: lru[0] is most recently used, lru[N-1] the oldest.
  logic [6:0] m_note [N];
  logic [6:0] m_vel [N];
  bit m_active [N];
  bit m_sus [N];
  int m_reopen [N];
  int lru [N];
  bit m_sustain;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_note[i] = '0; m_vel[i] = '0; m_active[i] = 0; m_sus[i] = 0; m_reopen[i] = 0;
      lru[i] = i;
    end
    m_sustain = 0;
  endtask

  task automatic touch(input int t);
    int p;
    p = 0;
    for (int i = 0; i < N; i++) if (lru[i] == t) p = i;
    for (int i = p; i > 0; i--) lru[i] = lru[i-1];
    lru[0] = t;
  endtask

  task automatic model_event(input logic [7:0] c, input logic [6:0] a, input logic [6:0] b);
    logic [3:0] k;
    int hit, tgt;
    k = c[7:4];
    if (k == 4'h9 && b != 0) begin
      hit = -1;
      for (int i = 0; i < N; i++) if (hit < 0 && m_active[i] && m_note[i] == a) hit = i;
      if (hit >= 0) begin
        m_vel[hit] = b; m_sus[hit] = 0; m_reopen[hit] = cyc + R; touch(hit);
      end else begin
        tgt = -1;
        for (int p = N - 1; p >= 0; p--) if (tgt < 0 && !m_active[lru[p]] && !m_sus[lru[p]]) tgt = lru[p];
        if (tgt < 0) begin tgt = lru[N-1]; m_reopen[tgt] = cyc + R; end
        else m_reopen[tgt] = cyc;
        m_active[tgt] = 1; m_note[tgt] = a; m_vel[tgt] = b; m_sus[tgt] = 0;
        touch(tgt);
      end
    end else if (k == 4'h8 || k == 4'h9) begin
      for (int i = 0; i < N; i++) begin
        if (m_active[i] && m_note[i] == a) begin
          if (m_sustain) m_sus[i] = 1;
          else begin m_active[i] = 0; m_sus[i] = 0; end
        end
      end
    end else if (k == 4'hB) begin
      if (a == 7'd64) begin
        m_sustain = (b >= 7'd64);
        if (!m_sustain)
          for (int i = 0; i < N; i++) if (m_sus[i]) begin m_active[i] = 0; m_sus[i] = 0; end
      end else if (a == 7'd120 || a == 7'd123) begin
        for (int i = 0; i < N; i++) begin m_active[i] = 0; m_sus[i] = 0; end
      end
    end
  endtask

  function automatic logic [N-1:0] exp_gate();
    logic [N-1:0] g;
    for (int i = 0; i < N; i++) g[i] = m_active[i] && (cyc >= m_reopen[i]);
    return g;
  endfunction

  function automatic logic [7*N-1:0] exp_notes();
    logic [7*N-1:0] v;
    for (int i = 0; i < N; i++) v[7*i +: 7] = m_note[i];
    return v;
  endfunction

  function automatic logic [7*N-1:0] exp_vels();
    logic [7*N-1:0] v;
    for (int i = 0; i < N; i++) v[7*i +: 7] = m_vel[i];
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid = 1'b0; valid3 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Drives one event on the omni instance; returns the ack seen just after the accepting edge.
  task automatic send_event(input logic [7:0] c, input logic [6:0] a, input logic [6:0] b,
                            output logic got_ack);
    @(negedge clk);
    cmd = c; p1 = a; p2 = b; valid = 1'b1;
    @(posedge clk); #1;
    got_ack = ack;
    model_event(c, a, b);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic send3(input logic [7:0] c, input logic [6:0] a, input logic [6:0] b,
                       output logic got_ack);
    @(negedge clk);
    cmd = c; p1 = a; p2 = b; valid3 = 1'b1;
    @(posedge clk); #1;
    got_ack = ack3;
    @(negedge clk);
    valid3 = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (ack !== 1'b0) begin $display("FAIL reset_ack: got %b want 0", ack); fails++; end
    tests++; if (gate !== '0) begin $display("FAIL reset_gate: got %b want 0", gate); fails++; end
    tests++; if (note !== '0 || vel !== '0) begin
      $display("FAIL reset_note_vel: got %h/%h want 0/0", note, vel); fails++; end
    tests++; if (gate3 !== '0 || ack3 !== 1'b0) begin
      $display("FAIL reset_ch3: got gate %b ack %b want 0", gate3, ack3); fails++; end
  endtask

  task automatic test_basic();
    logic a;
    do_reset();
    send_event(8'h90, 7'd60, 7'd100, a);
    tests++; if (a !== 1'b1) begin $display("FAIL basic_ack: got %b want 1", a); fails++; end
    @(posedge clk); #1;
    tests++; if (ack !== 1'b0) begin $display("FAIL basic_ack_drop: got %b want 0", ack); fails++; end
    send_event(8'h90, 7'd62, 7'd90, a);
    send_event(8'h90, 7'd64, 7'd80, a);
    // Reset ages are age[i]=i, so the highest-index slot is the first free pick.
    tests++; if (gate !== 4'b1110) begin $display("FAIL basic_gate: got %b want 1110", gate); fails++; end
    tests++; if (note[21 +: 7] !== 7'd60 || note[14 +: 7] !== 7'd62 || note[7 +: 7] !== 7'd64) begin
      $display("FAIL basic_notes: got %h want 3c/3e/40 in slots 3/2/1", note); fails++; end
    tests++; if (vel[14 +: 7] !== 7'd90) begin
      $display("FAIL basic_vel: got %0d want 90", vel[14 +: 7]); fails++; end
  endtask

  task automatic test_steal();
    logic a;
    logic [N-1:0] want;
    do_reset();
    send_event(8'h90, 7'd60, 7'd100, a);
    send_event(8'h90, 7'd62, 7'd100, a);
    send_event(8'h90, 7'd64, 7'd100, a);
    send_event(8'h90, 7'd65, 7'd100, a);
    tests++; if (gate !== 4'b1111) begin $display("FAIL steal_full: got %b want 1111", gate); fails++; end
    send_event(8'h90, 7'd67, 7'd55, a);
    tests++; if (note[21 +: 7] !== 7'd67 || gate !== 4'b0111) begin
      $display("FAIL steal_target: got note %0d gate %b want 67 0111", note[21 +: 7], gate); fails++; end
    for (int k = 1; k <= R; k++) begin
      @(negedge clk);
      want = (k >= R) ? 4'b1111 : 4'b0111;
      tests++; if (gate !== want) begin
        $display("FAIL steal_retrig_%0d: got %b want %b", k, gate, want); fails++; end
    end
    send_event(8'h90, 7'd69, 7'd40, a);
    tests++; if (note[14 +: 7] !== 7'd69 || gate !== 4'b1011) begin
      $display("FAIL steal_second: got note %0d gate %b want 69 1011", note[14 +: 7], gate); fails++; end
  endtask

  task automatic test_note_off();
    logic a;
    do_reset();
    send_event(8'h90, 7'd60, 7'd100, a);
    send_event(8'h90, 7'd60, 7'd0, a);
    tests++; if (gate !== 4'b0000 || note[21 +: 7] !== 7'd60 || vel[21 +: 7] !== 7'd100) begin
      $display("FAIL noteoff_vel0: got gate %b note %0d vel %0d want 0000 60 100",
               gate, note[21 +: 7], vel[21 +: 7]); fails++; end
    send_event(8'h80, 7'd50, 7'd0, a);
    tests++; if (a !== 1'b1 || gate !== 4'b0000) begin
      $display("FAIL noteoff_unheld: got ack %b gate %b want 1 0000", a, gate); fails++; end
  endtask

  task automatic test_sustain();
    logic a;
    do_reset();
    send_event(8'hB0, 7'd64, 7'd127, a);
    send_event(8'h90, 7'd60, 7'd100, a);
    send_event(8'h80, 7'd60, 7'd0, a);
    tests++; if (gate !== 4'b1000) begin $display("FAIL sustain_hold: got %b want 1000", gate); fails++; end
    send_event(8'hB0, 7'd64, 7'd0, a);
    tests++; if (gate !== 4'b0000) begin $display("FAIL sustain_release: got %b want 0000", gate); fails++; end
  endtask

  task automatic test_channel();
    logic a;
    do_reset();
    send3(8'h93, 7'd60, 7'd100, a);
    send3(8'h93, 7'd62, 7'd90, a);
    send3(8'h93, 7'd64, 7'd80, a);
    tests++; if (gate3 !== 4'b1110) begin $display("FAIL chan_fill: got %b want 1110", gate3); fails++; end
    send3(8'h95, 7'd67, 7'd100, a);
    tests++; if (a !== 1'b1 || gate3 !== 4'b1110 || note3[0 +: 7] !== 7'd0) begin
      $display("FAIL chan_filter: got ack %b gate %b want 1 1110", a, gate3); fails++; end
    send3(8'hB3, 7'd123, 7'd0, a);
    tests++; if (gate3 !== 4'b0000) begin $display("FAIL chan_cc123: got %b want 0000", gate3); fails++; end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    cmd = 8'h90; p1 = 7'd60; p2 = 7'd100; valid = 1'b1;
    @(posedge clk); #1;
    model_event(8'h90, 7'd60, 7'd100);
    tests++; if (ack !== 1'b1) begin $display("FAIL b2b_ack0: got %b want 1", ack); fails++; end
    @(negedge clk);
    p1 = 7'd62; p2 = 7'd90;
    @(posedge clk); #1;
    tests++; if (ack !== 1'b0) begin $display("FAIL b2b_gap: got %b want 0", ack); fails++; end
    @(posedge clk); #1;
    model_event(8'h90, 7'd62, 7'd90);
    tests++; if (ack !== 1'b1) begin $display("FAIL b2b_ack1: got %b want 1", ack); fails++; end
    @(negedge clk);
    valid = 1'b0;
    tests++; if (gate !== exp_gate() || note !== exp_notes()) begin
      $display("FAIL b2b_state: got %b %h want %b %h", gate, note, exp_gate(), exp_notes()); fails++; end
  endtask

  task automatic test_reset_retrig();
    logic a;
    do_reset();
    send_event(8'h90, 7'd60, 7'd100, a);
    send_event(8'h90, 7'd62, 7'd100, a);
    send_event(8'h90, 7'd64, 7'd100, a);
    send_event(8'h90, 7'd65, 7'd100, a);
    send_event(8'h90, 7'd67, 7'd100, a);
    rst = 1'b1; valid = 1'b1; cmd = 8'h90; p1 = 7'd70; p2 = 7'd50;
    @(posedge clk); #1;
    tests++; if (ack !== 1'b0 || gate !== '0 || note !== '0 || vel !== '0) begin
      $display("FAIL rst_retrig_clear: got ack %b gate %b note %h vel %h want all 0", ack, gate, note, vel);
      fails++; end
    @(posedge clk); #1;
    tests++; if (ack !== 1'b0) begin $display("FAIL rst_retrig_noack: got %b want 0", ack); fails++; end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    model_event(8'h90, 7'd70, 7'd50);
    tests++; if (ack !== 1'b1) begin $display("FAIL rst_retrig_ack: got %b want 1", ack); fails++; end
    @(negedge clk);
    valid = 1'b0;
    tests++; if (gate !== 4'b1000 || note[21 +: 7] !== 7'd70) begin
      $display("FAIL rst_retrig_after: got gate %b note %0d want 1000 70", gate, note[21 +: 7]); fails++; end
  endtask

  task automatic test_random();
    logic a;
    logic [7:0] c;
    logic [6:0] n, v;
    logic [3:0] ch;
    int r;
    do_reset();
    repeat (150) begin
      r  = $urandom_range(0, 9);
      ch = 4'($urandom_range(0, 15));
      n  = 7'(60 + $urandom_range(0, 5));
      v  = 7'($urandom_range(1, 127));
      case (r)
        0, 1, 2, 3: c = {4'h9, ch};
        4: begin c = {4'h9, ch}; v = 7'd0; end
        5, 6: c = {4'h8, ch};
        7: begin c = {4'hB, ch}; n = 7'd64; v = 7'($urandom_range(0, 127)); end
        8: begin c = {4'hB, ch}; n = ($urandom_range(0, 3) == 0) ? 7'd123 : 7'd7; end
        default: c = {4'hA, ch};
      endcase
      send_event(c, n, v, a);
      tests++; if (a !== 1'b1) begin $display("FAIL rand_ack: got %b want 1", a); fails++; end
      tests++; if (gate !== exp_gate() || note !== exp_notes() || vel !== exp_vels()) begin
        $display("FAIL rand_state cmd %h %0d %0d: got %b %h %h want %b %h %h", c, n, v,
                 gate, note, vel, exp_gate(), exp_notes(), exp_vels()); fails++; end
      repeat ($urandom_range(0, 5)) begin
        @(negedge clk);
        tests++; if (gate !== exp_gate()) begin
          $display("FAIL rand_gate_idle: got %b want %b", gate, exp_gate()); fails++; end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_steal();
    test_note_off();
    test_sustain();
    test_channel();
    test_back_to_back();
    test_reset_retrig();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
